// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with 2-entry skid buffer and flush
// Optional perf counters enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH      = 64,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0,
  parameter int unsigned       PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [PERF_W-1:0] bubble_cnt,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_d_q, main_d_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  logic             in_ready_q, in_ready_d;
  logic             acc, fire;

  assign acc  = in_valid & in_ready_q;
  assign fire = main_v_q & out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      // Held entries and any word accepted this cycle are dropped; data regs keep their value.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (acc) begin
        main_v_d = 1'b1;
        main_d_d = in_data;
      end
    end else if (!skid_v_q) begin
      if (fire && acc) begin
        main_d_d = in_data;
      end else if (fire) begin
        main_v_d = 1'b0;
      end else if (acc) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data;
      end
    end else if (fire) begin
      main_d_d = skid_d_q;
      skid_v_d = 1'b0;
    end
    in_ready_d = ~skid_v_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      main_d_q   <= RESET_DATA;
      skid_d_q   <= RESET_DATA;
      in_ready_q <= 1'b1;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      main_d_q   <= main_d_d;
      skid_d_q   <= skid_d_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_d_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

`ifdef PIPE_STAGE_REG_PERF_EN
  localparam logic [PERF_W-1:0] PerfOne = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] bubble_q, bubble_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  // Saturating counters; flush intentionally leaves them untouched.
  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (out_ready && !main_v_q && !(&bubble_q)) bubble_d = bubble_q + PerfOne;
    if (in_valid && !in_ready_q && !(&stall_q)) stall_d = stall_q + PerfOne;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end

  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector bench for pipe_stage_reg
module tb_pipe_stage_reg;
  localparam int W = 16;
  localparam logic [W-1:0] RD = 16'hDEAD;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0]  bubble_cnt, stall_cnt;
  logic [1:0]   s_bubble, s_stall, s_occ;
  logic         s_ir, s_ov;
  logic [W-1:0] s_od;

  pipe_stage_reg #(.WIDTH(W), .RESET_DATA(RD), .PERF_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_ir), .in_data(in_data),
    .flush(flush), .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od),
    .occupancy(s_occ), .bubble_cnt(s_bubble), .stall_cnt(s_stall));
`endif

  pipe_stage_reg #(.WIDTH(W), .RESET_DATA(RD), .PERF_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
    logic [1:0]   occ;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(logic iv, logic [W-1:0] d, logic ordy, logic fl,
                              logic ov, logic [W-1:0] od, logic ir, logic [1:0] occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
  endtask

  initial begin
    // Streaming 1..10 at full rate, then drain.
    add(1, 16'd1, 1, 0, 0, RD, 1, 0);
    for (int k = 2; k <= 10; k++) add(1, k[W-1:0], 1, 0, 1, W'(k - 1), 1, 1);
    add(0, 16'h0, 1, 0, 1, 16'd10, 1, 1);
    add(0, 16'h0, 1, 0, 0, 16'd10, 1, 0);
    // Backpressure A,B,C then release; cycle 17 is fire+accept with skid empty.
    add(1, 16'h000A, 0, 0, 0, 16'd10,   1, 0);
    add(1, 16'h000B, 0, 0, 1, 16'h000A, 1, 1);
    add(1, 16'h000C, 0, 0, 1, 16'h000A, 0, 2);
    add(1, 16'h000C, 1, 0, 1, 16'h000A, 0, 2);
    add(1, 16'h000C, 1, 0, 1, 16'h000B, 1, 1);
    add(0, 16'h0,    1, 0, 1, 16'h000C, 1, 1);
    add(0, 16'h0,    0, 0, 0, 16'h000C, 1, 0);
    // Flush with two entries, flush discarding an accept, flush at occupancy 1.
    add(1, 16'h0011, 0, 0, 0, 16'h000C, 1, 0);
    add(1, 16'h0022, 0, 0, 1, 16'h0011, 1, 1);
    add(1, 16'h00DD, 0, 1, 1, 16'h0011, 0, 2);
    add(1, 16'h00D0, 0, 1, 0, 16'h0011, 1, 0);
    add(0, 16'h0,    1, 0, 0, 16'h0011, 1, 0);
    add(1, 16'h0033, 0, 0, 0, 16'h0011, 1, 0);
    add(1, 16'h00D1, 1, 1, 1, 16'h0033, 1, 1);
    add(0, 16'h0,    1, 0, 0, 16'h0033, 1, 0);

    reset = 1'b1;
    drive(0, '0, 0, 0);
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'(RD));
    reset = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      #2;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].od));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].ir));
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      step();
    end

    // Asynchronous reset between edges with two entries held.
    drive(1, 16'h0055, 0, 0);
    step();
    drive(1, 16'h0066, 0, 0);
    step();
    drive(0, '0, 0, 0);
    chk("pre_rst_occupancy", 32'(occupancy), 32'd2);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_occupancy", 32'(occupancy), 32'd0);
    chk("async_rst_in_ready",  32'(in_ready),  32'd1);
    chk("async_rst_out_data",  32'(out_data),  32'(RD));
    #2 reset = 1'b0;
    step();

    // Flush and reset together: reset wins, nothing accepted.
    drive(1, 16'h0077, 1, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, '0, 0, 0);
    chk("rst_flush_occupancy", 32'(occupancy), 32'd0);
    chk("rst_flush_out_data",  32'(out_data),  32'(RD));
    step();

`ifdef PIPE_STAGE_REG_PERF_EN
    reset = 1'b1;
    #2 reset = 1'b0;
    step();
    drive(0, '0, 1, 0);
    repeat (5) step();
    drive(0, '0, 0, 0);
    chk("bubble_cnt_5", bubble_cnt, 32'd5);
    drive(1, 16'h0001, 0, 0);
    step();
    drive(1, 16'h0002, 0, 0);
    step();
    repeat (3) step();
    chk("stall_cnt_3", stall_cnt, 32'd3);
    repeat (3) step();
    drive(0, '0, 0, 0);
    chk("stall_cnt_6",       stall_cnt,       32'd6);
    chk("stall_cnt_sat_w2",  32'(s_stall),    32'd3);
    chk("bubble_cnt_held",   bubble_cnt,      32'd5);
    drive(0, '0, 0, 1);
    step();
    drive(0, '0, 0, 0);
    chk("flush_keeps_stall", stall_cnt, 32'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
